// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge.
module mem_lane_mux
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word_i[{lane_i, 3'b000} +: 8];
    half_sel    = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = word_i;
    merged_o    = new_data_i;
    // Size 2'b11 is reserved and falls through to the whole-word behaviour.
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merged_o    = word_i;
        merged_o[{lane_i, 3'b000} +: 8] = new_data_i[7:0];
      end
      SZ_HALF: begin
        load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        merged_o    = word_i;
        merged_o[{lane_i[1], 4'b0000} +: 16] = new_data_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: loads in one cycle, sub-word stores as a stalled read-modify-write.
// Define MEM_ALIGN_CHECK_EN to enable misalignment and range checking on addr_err.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        addr_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] merged;
  logic        err;

  mem_lane_mux u_lane_mux (
    .word_i      (mem_rdata),
    .new_data_i  (req_wdata),
    .lane_i      (req_addr[1:0]),
    .size_i      (req_size),
    .signed_i    (req_signed),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  assign mem_address = {req_addr[31:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    err          = (req_read || req_write) && (state_q == IDLE) &&
                   (misaligned || out_of_range);
  end
`else
  assign err = 1'b0;
`endif

  assign addr_err = err;

  always_comb begin
    state_d    = state_q;
    merge_d    = merge_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = req_wdata;
    load_valid = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        // A store takes priority over a simultaneous load.
        if (err) begin
          state_d = IDLE;
        end else if (req_write) begin
          if (req_size[1]) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            merge_d  = merged;
            state_d  = RMW_WR;
          end
        end else if (req_read) begin
          mem_read   = 1'b1;
          load_valid = 1'b1;
        end
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_wdata = merge_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule
